// File: rtl/avmm_word_mem_responder_if.sv
// Avalon-MM single-word command/response bundle between an accelerator master and a memory slave.
// Latency: none (wires only).
// Backpressure: the slave drives waitrequest; the master holds its command until it is low.
interface avmm_word_mem_responder_if;
  logic        waitrequest;
  logic [31:0] address;
  logic        read;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        write;
  logic [31:0] writedata;

  modport master (
    input  waitrequest, readdata, readdatavalid,
    output address, read, write, writedata
  );

  modport slave (
    output waitrequest, readdata, readdatavalid,
    input  address, read, write, writedata
  );
endinterface

// File: rtl/avmm_word_mem_responder.sv
// Avalon-MM word memory responder with programmable wait states and a backdoor preload port.
// Latency: writes land at acceptance; read data returns READ_LATENCY cycles after acceptance.
// Backpressure: waitrequest is held for WAIT_CYCLES per command and whenever MAX_PENDING reads are in flight.
module avmm_word_mem_responder #(
  parameter int ADDR_WORDS   = 1024,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  avmm_word_mem_responder_if.slave      slave,
  input  logic                          bd_we,
  input  logic [$clog2(ADDR_WORDS)-1:0] bd_addr,
  input  logic [31:0]                   bd_wdata,
  output logic [15:0]                   rd_count,
  output logic [15:0]                   wr_count,
  output logic                          proto_err
);

  localparam int AW  = $clog2(ADDR_WORDS);
  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int PW  = $clog2(MAX_PENDING + 1);
  localparam logic [WCW-1:0] WAIT_L = WCW'(WAIT_CYCLES);
  localparam logic [PW-1:0]  MAXP_L = PW'(MAX_PENDING);

  logic [31:0]             mem [ADDR_WORDS];
  logic [WCW-1:0]          wcnt_q, wcnt_d;
  logic [PW-1:0]           pend_q, pend_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0]             dat_q [READ_LATENCY];
  logic [31:0]             dat_d [READ_LATENCY];
  logic [15:0]             rd_cnt_q, rd_cnt_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;
  logic                    perr_q, perr_d;

  logic [AW-1:0] idx;
  logic          cmd, wait_hold, wreq, acc, acc_wr, acc_rd, rsp_out;
  logic          unused_addr;

  // Byte address to word index; upper bits alias, lane bits are ignored.
  assign idx         = slave.address[AW+1:2];
  assign unused_addr = ^{slave.address[31:AW+2], slave.address[1:0]};

  // Wait-state stall only exists when wait cycles are configured.
  if (WAIT_CYCLES > 0) begin : g_wait
    assign wait_hold = (wcnt_q < WAIT_L);
  end else begin : g_nowait
    assign wait_hold = 1'b0;
  end

  assign cmd     = slave.read | slave.write;
  assign wreq    = wait_hold | (pend_q == MAXP_L) | !rst_n;
  assign acc     = cmd & !wreq;
  assign acc_wr  = acc & slave.write;
  // A read presented together with a write is dropped; only the write is served.
  assign acc_rd  = acc & slave.read & !slave.write;
  assign rsp_out = vld_q[READ_LATENCY-1];

  // Next-state for wait counter, pending count, counters, sticky error and read pipeline.
  always_comb begin
    wcnt_d = wcnt_q;
    if (acc || !cmd) begin
      wcnt_d = '0;
    end else if (wait_hold) begin
      wcnt_d = wcnt_q + WCW'(1);
    end

    // Pending uses the registered count, so a response leaving while full frees a slot next cycle.
    pend_d   = pend_q + PW'(acc_rd) - PW'(rsp_out);
    rd_cnt_d = rd_cnt_q + 16'(acc_rd);
    wr_cnt_d = wr_cnt_q + 16'(acc_wr);
    perr_d   = perr_q | (slave.read & slave.write);

    vld_d    = '0;
    vld_d[0] = acc_rd;
    dat_d[0] = acc_rd ? mem[idx] : dat_q[0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      // Stages only load on a valid beat so the output stage holds the last returned word.
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  // Control and pipeline registers; reset flushes in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q   <= '0;
      pend_q   <= '0;
      vld_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      perr_q   <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      pend_q   <= pend_d;
      vld_q    <= vld_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      perr_q   <= perr_d;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  // Storage array: kept across reset; the Avalon write is last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (bd_we)  mem[bd_addr] <= bd_wdata;
    if (acc_wr) mem[idx]     <= slave.writedata;
  end

  assign slave.waitrequest   = wreq;
  assign slave.readdatavalid = vld_q[READ_LATENCY-1];
  assign slave.readdata      = dat_q[READ_LATENCY-1];
  assign rd_count            = rd_cnt_q;
  assign wr_count            = wr_cnt_q;
  assign proto_err           = perr_q;

endmodule

// File: tb/tb_avmm_word_mem_responder.sv
// Bench for avmm_word_mem_responder: three differently configured instances against a word-array model.
// Read responses are checked by a scoreboard for data, order and the exact return cycle.
// Stall lengths are checked against the configured wait states and pending limit.
module tb_avmm_word_mem_responder;
  localparam int NI    = 3;
  localparam int DEPTH = 1024;
  localparam int WAITP [NI] = '{1, 0, 0};
  localparam int LAT   [NI] = '{2, 2, 3};
  localparam int MAXP  [NI] = '{4, 4, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_i   [NI];
  logic        rd_i      [NI];
  logic        wr_i      [NI];
  logic [31:0] addr_i    [NI];
  logic [31:0] wdat_i    [NI];
  logic        bd_we_i   [NI];
  logic [9:0]  bd_addr_i [NI];
  logic [31:0] bd_wd_i   [NI];
  logic        wreq_o    [NI];
  logic        rdv_o     [NI];
  logic        perr_o    [NI];
  logic [31:0] rdata_o   [NI];
  logic [15:0] rdc_o     [NI];
  logic [15:0] wrc_o     [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    avmm_word_mem_responder_if bus ();
    assign bus.address   = addr_i[k];
    assign bus.read      = rd_i[k];
    assign bus.write     = wr_i[k];
    assign bus.writedata = wdat_i[k];
    assign wreq_o[k]     = bus.waitrequest;
    assign rdv_o[k]      = bus.readdatavalid;
    assign rdata_o[k]    = bus.readdata;

    avmm_word_mem_responder #(
      .ADDR_WORDS(DEPTH), .WAIT_CYCLES(WAITP[k]),
      .READ_LATENCY(LAT[k]), .MAX_PENDING(MAXP[k])
    ) dut (
      .clk(clk), .rst_n(rst_n_i[k]), .slave(bus.slave),
      .bd_we(bd_we_i[k]), .bd_addr(bd_addr_i[k]), .bd_wdata(bd_wd_i[k]),
      .rd_count(rdc_o[k]), .wr_count(wrc_o[k]), .proto_err(perr_o[k])
    );
  end

  typedef struct {
    int          k;
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mm [NI][DEPTH];
  int          rdm [NI];
  int          wrm [NI];
  bit          perm [NI];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every valid must match the oldest outstanding read of that instance at its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NI; k++) begin
        int fi;
        fi = -1;
        for (int i = 0; i < sbq.size(); i++) begin
          if (sbq[i].k == k) begin fi = i; break; end
        end
        if (rdv_o[k] === 1'b1) begin
          n_cmp++;
          if (fi < 0) begin
            n_fail++;
            $display("FAIL stray_valid: inst %0d cycle %0d got valid data %h, want no response", k, cyc, rdata_o[k]);
          end else begin
            if (rdata_o[k] !== sbq[fi].d || cyc != sbq[fi].due) begin
              n_fail++;
              $display("FAIL read_resp: inst %0d got %h at cycle %0d, want %h at cycle %0d",
                       k, rdata_o[k], cyc, sbq[fi].d, sbq[fi].due);
            end
            sbq.delete(fi);
          end
        end else if (fi >= 0 && sbq[fi].due <= cyc) begin
          n_cmp++;
          n_fail++;
          $display("FAIL missing_valid: inst %0d no valid at cycle %0d, want %h", k, cyc, sbq[fi].d);
          sbq.delete(fi);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one command, hold it until accepted, and update the model at the acceptance edge.
  task automatic do_cmd(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int waits);
    int idx;
    bit ok;
    idx = int'((a >> 2) % DEPTH);
    rd_i[k] = r; wr_i[k] = w; addr_i[k] = a; wdat_i[k] = d;
    waits = 0;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (wreq_o[k] === 1'b0) begin ok = 1'b1; break; end
      waits++;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: inst %0d still stalled after %0d cycles, want acceptance", k, waits);
    end else begin
      if (w) begin mm[k][idx] = d; wrm[k]++; end
      if (r && w) perm[k] = 1'b1;
      if (r && !w) begin
        sbq.push_back('{k: k, d: mm[k][idx], due: cyc + LAT[k]});
        rdm[k]++;
      end
    end
    @(posedge clk);
    #1;
    rd_i[k] = 1'b0; wr_i[k] = 1'b0;
  endtask

  task automatic bd_write(input int k, input int a, input logic [31:0] d);
    bd_we_i[k] = 1'b1; bd_addr_i[k] = 10'(a); bd_wd_i[k] = d;
    @(posedge clk);
    #1;
    bd_we_i[k] = 1'b0;
    mm[k][a] = d;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      rst_n_i[k] = 1'b0; rd_i[k] = 1'b0; wr_i[k] = 1'b0; addr_i[k] = '0; wdat_i[k] = '0;
      bd_we_i[k] = 1'b0; bd_addr_i[k] = '0; bd_wd_i[k] = '0;
      rdm[k] = 0; wrm[k] = 0; perm[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (wreq_o[k] !== 1'b1 || rdv_o[k] !== 1'b0 || rdata_o[k] !== 32'h0 ||
          rdc_o[k] !== 16'h0 || wrc_o[k] !== 16'h0 || perr_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: inst %0d got wreq=%b vld=%b data=%h rd=%0d wr=%0d perr=%b, want 1 0 0 0 0 0",
                 k, wreq_o[k], rdv_o[k], rdata_o[k], rdc_o[k], wrc_o[k], perr_o[k]);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst_n_i[k] = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_write_read();
    int w;
    do_cmd(0, 1'b0, 1'b1, 32'h40, 32'h10, w);
    n_cmp++;
    if (w != 1) begin n_fail++; $display("FAIL wr_stall: got %0d wait cycles, want 1", w); end
    do_cmd(0, 1'b1, 1'b0, 32'h40, 32'h0, w);
    n_cmp++;
    if (w != 1) begin n_fail++; $display("FAIL rd_stall: got %0d wait cycles, want 1", w); end
    idle(5);
    n_cmp++;
    if (rdc_o[0] !== 16'd1 || wrc_o[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_counts: got rd=%0d wr=%0d, want 1 1", rdc_o[0], wrc_o[0]);
    end
    n_cmp++;
    if (rdata_o[0] !== 32'h10) begin
      n_fail++;
      $display("FAIL readdata_hold: got %h, want 00000010", rdata_o[0]);
    end
  endtask

  task automatic test_sweep();
    int w;
    int vals [4] = '{3, 5, 7, 9};
    for (int i = 0; i < 4; i++) bd_write(1, i, 32'(vals[i]));
    for (int i = 0; i < 4; i++) begin
      do_cmd(1, 1'b1, 1'b0, 32'(i * 4), 32'h0, w);
      n_cmp++;
      if (w != 0) begin n_fail++; $display("FAIL sweep_stall: read %0d got %0d wait cycles, want 0", i, w); end
    end
    idle(6);
    n_cmp++;
    if (rdc_o[1] !== 16'(rdm[1]) || wrc_o[1] !== 16'(wrm[1])) begin
      n_fail++;
      $display("FAIL sweep_counts: got rd=%0d wr=%0d, want %0d %0d", rdc_o[1], wrc_o[1], rdm[1], wrm[1]);
    end
  endtask

  task automatic test_pending();
    int w1, w2;
    bd_write(2, 0, 32'hA0A0_0000);
    bd_write(2, 1, 32'hB1B1_0001);
    do_cmd(2, 1'b1, 1'b0, 32'h0, 32'h0, w1);
    do_cmd(2, 1'b1, 1'b0, 32'h4, 32'h0, w2);
    n_cmp++;
    if (w1 != 0 || w2 != LAT[2]) begin
      n_fail++;
      $display("FAIL pending_stall: got waits %0d/%0d, want 0/%0d", w1, w2, LAT[2]);
    end
    idle(8);
    n_cmp++;
    if (rdc_o[2] !== 16'd2) begin n_fail++; $display("FAIL pending_count: got %0d, want 2", rdc_o[2]); end
  endtask

  task automatic test_alias();
    int w;
    do_cmd(0, 1'b0, 1'b1, 32'h0000_1004, 32'hAAAA_5555, w);
    do_cmd(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, w);
    do_cmd(0, 1'b1, 1'b0, 32'h0000_0007, 32'h0, w);
    idle(6);
    n_cmp++;
    if (mm[0][1] !== 32'hAAAA_5555) begin
      n_fail++;
      $display("FAIL alias_model: model word 1 got %h, want aaaa5555", mm[0][1]);
    end
  endtask

  task automatic test_proto();
    int w;
    do_cmd(0, 1'b1, 1'b1, 32'h8, 32'h1234, w);
    idle(3);
    n_cmp++;
    if (perr_o[0] !== 1'b1 || rdc_o[0] !== 16'(rdm[0]) || wrc_o[0] !== 16'(wrm[0])) begin
      n_fail++;
      $display("FAIL proto_set: got perr=%b rd=%0d wr=%0d, want 1 %0d %0d", perr_o[0], rdc_o[0], wrc_o[0], rdm[0], wrm[0]);
    end
    idle(4);
    n_cmp++;
    if (perr_o[0] !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %b, want 1", perr_o[0]); end
    do_cmd(0, 1'b1, 1'b0, 32'h8, 32'h0, w);
    idle(5);
  endtask

  task automatic test_bd_collision();
    int w;
    wr_i[1] = 1'b1; addr_i[1] = 32'h20; wdat_i[1] = 32'h1111_1111;
    bd_we_i[1] = 1'b1; bd_addr_i[1] = 10'd8; bd_wd_i[1] = 32'h2222_2222;
    @(negedge clk);
    n_cmp++;
    if (wreq_o[1] !== 1'b0) begin n_fail++; $display("FAIL collide_stall: got wreq=%b, want 0", wreq_o[1]); end
    mm[1][8] = 32'h1111_1111;
    wrm[1]++;
    @(posedge clk);
    #1;
    wr_i[1] = 1'b0; bd_we_i[1] = 1'b0;
    do_cmd(1, 1'b1, 1'b0, 32'h20, 32'h0, w);
    idle(5);
    n_cmp++;
    if (wrc_o[1] !== 16'(wrm[1])) begin
      n_fail++;
      $display("FAIL collide_count: got wr=%0d, want %0d", wrc_o[1], wrm[1]);
    end
  endtask

  task automatic test_random();
    int w;
    bit r;
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) bd_write(k, i, $urandom);
      for (int n = 0; n < 40; n++) begin
        r = 1'($urandom_range(0, 1));
        a = $urandom & 32'hFFFF_F03F;
        do_cmd(k, r, !r, a, $urandom, w);
        n_cmp++;
        if (w != WAITP[k]) begin
          n_fail++;
          $display("FAIL rand_stall: inst %0d op %0d got %0d wait cycles, want %0d", k, n, w, WAITP[k]);
        end
        idle($urandom_range(0, 2));
      end
      idle(6);
      n_cmp++;
      if (rdc_o[k] !== 16'(rdm[k]) || wrc_o[k] !== 16'(wrm[k])) begin
        n_fail++;
        $display("FAIL rand_counts: inst %0d got rd=%0d wr=%0d, want %0d %0d", k, rdc_o[k], wrc_o[k], rdm[k], wrm[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bd_write(2, 5, 32'hDEAD_0005);
    do_cmd(2, 1'b1, 1'b0, 32'h14, 32'h0, w);
    rst_n_i[2] = 1'b0;
    for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].k == 2) sbq.delete(i);
    rdm[2] = 0; wrm[2] = 0; perm[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (wreq_o[2] !== 1'b1 || rdv_o[2] !== 1'b0 || rdata_o[2] !== 32'h0 ||
        rdc_o[2] !== 16'h0 || wrc_o[2] !== 16'h0 || perr_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: got wreq=%b vld=%b data=%h rd=%0d wr=%0d perr=%b, want 1 0 0 0 0 0",
               wreq_o[2], rdv_o[2], rdata_o[2], rdc_o[2], wrc_o[2], perr_o[2]);
    end
    @(posedge clk);
    #1;
    rst_n_i[2] = 1'b1;
    idle(8);
    do_cmd(2, 1'b1, 1'b0, 32'h14, 32'h0, w);
    n_cmp++;
    if (w != 0) begin n_fail++; $display("FAIL midreset_stall: got %0d wait cycles, want 0", w); end
    idle(6);
    n_cmp++;
    if (rdc_o[2] !== 16'd1) begin n_fail++; $display("FAIL midreset_count: got %0d, want 1", rdc_o[2]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_sweep();
    test_pending();
    test_alias();
    test_proto();
    test_bd_collision();
    test_random();
    test_reset_mid();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_reads: got %0d outstanding, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/avmm_word_mem_responder.md
Name: avmm_word_mem_responder

Overview:
- Avalon-MM slave word memory: the responder end of the accelerator memory-master interface.
- Serves single-word reads and writes from the dot-product accelerator and future accelerators.
- Programmable wait states and fixed pipelined read latency, signalled with readdatavalid.
- Used as on-chip weight/activation store and as the bench memory for accelerator masters.

Parameters:
- ADDR_WORDS, 1024: memory depth in 32-bit words (power of two).
- WAIT_CYCLES, 1: waitrequest cycles inserted before each command is accepted (0 = zero-wait).
- READ_LATENCY, 2: cycles from read acceptance to readdatavalid (>=1).
- MAX_PENDING, 4: max reads accepted but not yet returned (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- slave_waitrequest  out  1  stall to master
- slave_address  in  32  byte address
- slave_read  in  1  read command
- slave_readdata  out  32  read data
- slave_readdatavalid  out  1  readdata valid strobe
- slave_write  in  1  write command
- slave_writedata  in  32  write data
- bd_we  in  1  backdoor write enable (bench/preload)
- bd_addr  in  $clog2(ADDR_WORDS)  backdoor word address
- bd_wdata  in  32  backdoor write data
- rd_count  out  16  accepted-read counter
- wr_count  out  16  accepted-write counter
- proto_err  out  1  sticky: read and write asserted together

Behaviour:
- Reset: clk and rst_n as decided; synchronous, active-low.
- While rst_n=0: waitrequest=1, readdatavalid=0, readdata=0, rd_count=0, wr_count=0, proto_err=0, wait counter=0, pipeline flushed. Memory contents are NOT cleared.
- Addressing: word index = slave_address[$clog2(ADDR_WORDS)+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses alias modulo ADDR_WORDS*4.
- Wait counter wcnt:
  - Increments each cycle a command (read|write) is asserted and wcnt<WAIT_CYCLES.
  - Clears to 0 on the acceptance cycle.
  - Holds at 0 when no command is asserted.
- waitrequest (combinational) = (wcnt<WAIT_CYCLES) | (pending==MAX_PENDING) | !rst_n. It may be high with no command present.
- Acceptance: rising edge where (read|write) & !waitrequest. Each command is accepted exactly once. The master holds its signals until acceptance.
- Write accept: mem[idx] <= writedata at that edge; wr_count++ (wraps at 16 bits).
- Read accept:
  - mem[idx] is sampled at the acceptance edge.
  - Data and valid enter stage 1 of a READ_LATENCY-deep pipeline; rd_count++.
  - readdatavalid=1 with readdata for exactly one cycle, READ_LATENCY cycles after acceptance. READ_LATENCY=2: accept at edge t, valid during cycle after edge t+1.
- Read ordering: responses return in acceptance order; back-to-back reads yield back-to-back valids. readdata holds its last returned value when valid=0.
- Read-after-write: a write accepted at edge t is visible to a read accepted at edge t+1 or later.
- Pending count:
  - +1 on read accept, -1 when a response leaves the pipeline; both events in the same cycle leave it unchanged.
  - Full (pending==MAX_PENDING) forces waitrequest. A response leaving in that cycle does not release the stall until the next cycle.
- Read and write in the same cycle (protocol violation):
  - The write is performed; the read is dropped (no response, rd_count unchanged).
  - proto_err sets and stays set until reset.
- Backdoor:
  - bd_we writes mem[bd_addr] at the edge, independent of waitrequest.
  - If it collides with an accepted Avalon write to the same word, the Avalon write wins.
  - Counters are not affected.
- Reset mid-operation: in-flight read responses are discarded; no readdatavalid is issued after reset deasserts for reads accepted before reset.

Test Plan:
- WAIT_CYCLES=1, READ_LATENCY=2: write 0x0000_0010 to byte addr 0x40, then read 0x40 -> waitrequest high 1 cycle per command; readdata=0x10 with valid 2 cycles after read accept; wr_count=1, rd_count=1.
- Backdoor preload words 0..3 = {3,5,7,9}; master holds read high, sweeping addresses 0x0,0x4,0x8,0xC -> 4 in-order valid pulses with 3,5,7,9; no stall with WAIT_CYCLES=0, MAX_PENDING=4.
- MAX_PENDING=1, READ_LATENCY=3: issue 2 reads back-to-back -> second held by waitrequest until the cycle after the first valid; exactly 2 valids, order preserved.
- Address aliasing: ADDR_WORDS=1024, write 0xAAAA_5555 to 0x0000_1004 and read 0x0000_0004, also 0x0000_0007 -> both return 0xAAAA_5555.
- Assert read and write together at 0x8 with writedata 0x1234 -> mem[2]=0x1234, no readdatavalid, proto_err=1 and sticky; rd_count unchanged.
- Reset asserted one cycle after a read accept with READ_LATENCY=3 -> no readdatavalid afterwards, counters=0, a subsequent read still returns pre-reset memory contents.
